// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: result bus, register index and queue entry.
package writeback_unit_pkg;

    typedef logic [31:0] bus_t;
    typedef logic [4:0]  reg_idx_t;

    typedef struct packed {
        reg_idx_t rd;
        bus_t     data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    function automatic logic [31:0] rd_onehot(input reg_idx_t rd);
        return 32'b1 << rd;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Producer handshakes, register-file write port and pending mask of the writeback unit.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic        alu_valid;
    logic        alu_ready;
    reg_idx_t    alu_rd;
    bus_t        alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    reg_idx_t    lsu_rd;
    bus_t        lsu_data;
    logic        rf_enable;
    logic [5:0]  rf_write_addr;
    bus_t        rf_data;
    logic [31:0] pending;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, rf_enable, rf_write_addr, rf_data, pending
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, rf_enable, rf_write_addr, rf_data, pending
    );

endinterface

// File: rtl/writeback_unit_queue.sv
// Per-producer result FIFO; every slot is exported with a valid bit for the pending decode.
module wb_queue
    import writeback_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  wb_entry_t                       push_entry,
    input  logic                            pop,
    output wb_entry_t                       head,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(QDEPTH):0]         count,
    output wb_entry_t [QDEPTH-1:0]          entries,
    output logic [QDEPTH-1:0]               entry_valid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    wb_entry_t [QDEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slots are only observed through entry_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_comb begin
        logic [PW-1:0] off;
        entry_valid = '0;
        off         = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            off            = PW'(i) - rd_ptr;
            entry_valid[i] = (CW'(off) < count);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Round-robin merge of ALU and LSU results onto the single register-file write port,
// with a registered write stage and a mask of registers that still have writes in flight.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;

    wb_entry_t             alu_head, lsu_head, win_entry;
    wb_entry_t [QDEPTH-1:0] alu_entries, lsu_entries;
    logic [QDEPTH-1:0]     alu_ev, lsu_ev;
    logic [CW-1:0]         alu_count, lsu_count;
    logic                  alu_full, lsu_full, alu_empty, lsu_empty;
    logic                  alu_push, lsu_push;
    logic                  grant_alu, grant_lsu;
    src_t                  last_grant, last_grant_nxt;

    logic                  rf_enable_q;
    reg_idx_t              rf_rd_q;
    bus_t                  rf_data_q;
    logic [31:0]           pending_c;

    // rd == 0 completes the handshake but is dropped here.
    assign alu_push = bus.alu_valid && !alu_full && (bus.alu_rd != '0);
    assign lsu_push = bus.lsu_valid && !lsu_full && (bus.lsu_rd != '0);

    assign bus.alu_ready = (alu_count < CW'(QDEPTH));
    assign bus.lsu_ready = (lsu_count < CW'(QDEPTH));

    wb_queue #(.QDEPTH(QDEPTH)) u_alu_q (
        .clk         (clk),
        .reset       (reset),
        .push        (alu_push),
        .push_entry  ('{rd: bus.alu_rd, data: bus.alu_data}),
        .pop         (grant_alu),
        .head        (alu_head),
        .full        (alu_full),
        .empty       (alu_empty),
        .count       (alu_count),
        .entries     (alu_entries),
        .entry_valid (alu_ev)
    );

    wb_queue #(.QDEPTH(QDEPTH)) u_lsu_q (
        .clk         (clk),
        .reset       (reset),
        .push        (lsu_push),
        .push_entry  ('{rd: bus.lsu_rd, data: bus.lsu_data}),
        .pop         (grant_lsu),
        .head        (lsu_head),
        .full        (lsu_full),
        .empty       (lsu_empty),
        .count       (lsu_count),
        .entries     (lsu_entries),
        .entry_valid (lsu_ev)
    );

    always_comb begin
        grant_alu      = 1'b0;
        grant_lsu      = 1'b0;
        last_grant_nxt = last_grant;
        if (!alu_empty && (lsu_empty || last_grant == SRC_LSU)) begin
            grant_alu      = 1'b1;
            last_grant_nxt = SRC_ALU;
        end else if (!lsu_empty) begin
            grant_lsu      = 1'b1;
            last_grant_nxt = SRC_LSU;
        end
    end

    assign win_entry = grant_alu ? alu_head : lsu_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= SRC_LSU;
            rf_enable_q <= 1'b0;
            rf_rd_q     <= '0;
            rf_data_q   <= '0;
        end else begin
            last_grant  <= last_grant_nxt;
            rf_enable_q <= grant_alu || grant_lsu;
            if (grant_alu || grant_lsu) begin
                rf_rd_q   <= win_entry.rd;
                rf_data_q <= win_entry.data;
            end
        end
    end

    assign bus.rf_enable     = rf_enable_q;
    assign bus.rf_write_addr = {1'b0, rf_rd_q};
    assign bus.rf_data       = rf_data_q;

    always_comb begin
        pending_c = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (alu_ev[i]) pending_c |= rd_onehot(alu_entries[i].rd);
            if (lsu_ev[i]) pending_c |= rd_onehot(lsu_entries[i].rd);
        end
        if (rf_enable_q) pending_c |= rd_onehot(rf_rd_q);
        pending_c[0] = 1'b0;
    end

    assign bus.pending = pending_c;

endmodule
